gcn_mem_fetch: RTL and testbench

//  Read initiator for the GCN shared matrix memory port (read_address/enable_read -> data_in).

---
 rtl/gcn_mem_fetch.sv | 159 +++++++++++++++
 tb/tb_gcn_mem_fetch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcn_mem_fetch.sv
// Read initiator for the GCN matrix memory: loads every weight vector into a local buffer,
// then streams the feature rows one by one to the FM*WM engine over valid/ready.
module gcn_mem_fetch #(
    parameter  int WEIGHT_ROWS   = 96,
    parameter  int WEIGHT_COLS   = 3,
    parameter  int FEATURE_ROWS  = 6,
    parameter  int WEIGHT_WIDTH  = 5,
    parameter  int ADDRESS_WIDTH = 13,
    parameter  int FEATURE_BASE  = 512,
    localparam int IDX_W         = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
    localparam int WC_W          = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic                                                    start,
    input  logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0]                data_in,
    output logic [ADDRESS_WIDTH-1:0]                                read_address,
    output logic                                                    enable_read,
    output logic [0:WEIGHT_COLS-1][0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] weight_buf,
    output logic                                                    weights_valid,
    output logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0]                fm_row_data,
    output logic [IDX_W-1:0]                                        fm_row_idx,
    output logic                                                    fm_row_valid,
    input  logic                                                    fm_row_ready,
    output logic                                                    done
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_ISSUE, S_W_CAPT, S_F_ISSUE, S_F_CAPT, S_F_HOLD, S_DONE
    } state_e;

    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WEIGHT_COLS - 1);
    localparam logic [IDX_W-1:0] FR_LAST = IDX_W'(FEATURE_ROWS - 1);

    state_e                                                  state_q, state_d;
    logic [WC_W-1:0]                                         wcnt_q, wcnt_d;
    logic [IDX_W-1:0]                                        fcnt_q, fcnt_d;
    logic [ADDRESS_WIDTH-1:0]                                addr_q, addr_d;
    logic                                                    en_q, en_d;
    logic [0:WEIGHT_COLS-1][0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] wbuf_q, wbuf_d;
    logic                                                    wvalid_q, wvalid_d;
    logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0]                row_q, row_d;
    logic [IDX_W-1:0]                                        ridx_q, ridx_d;
    logic                                                    rvalid_q, rvalid_d;
    logic                                                    done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            fcnt_q   <= '0;
            addr_q   <= '0;
            en_q     <= 1'b0;
            wbuf_q   <= '0;
            wvalid_q <= 1'b0;
            row_q    <= '0;
            ridx_q   <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            fcnt_q   <= fcnt_d;
            addr_q   <= addr_d;
            en_q     <= en_d;
            wbuf_q   <= wbuf_d;
            wvalid_q <= wvalid_d;
            row_q    <= row_d;
            ridx_q   <= ridx_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
        end
    end

    // Each read spans two states: ISSUE registers the address, CAPT holds it while
    // the combinational memory data is sampled, so enable_read is high only in CAPT.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        fcnt_d   = fcnt_q;
        addr_d   = addr_q;
        en_d     = en_q;
        wbuf_d   = wbuf_q;
        wvalid_d = wvalid_q;
        row_d    = row_q;
        ridx_d   = ridx_q;
        rvalid_d = rvalid_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wcnt_d  = '0;
                    state_d = S_W_ISSUE;
                end
            end
            S_W_ISSUE: begin
                addr_d  = ADDRESS_WIDTH'(wcnt_q);
                en_d    = 1'b1;
                state_d = S_W_CAPT;
            end
            S_W_CAPT: begin
                wbuf_d[wcnt_q] = data_in;
                en_d           = 1'b0;
                if (wcnt_q == WC_LAST) begin
                    wvalid_d = 1'b1;
                    fcnt_d   = '0;
                    state_d  = S_F_ISSUE;
                end else begin
                    wcnt_d  = wcnt_q + WC_W'(1);
                    state_d = S_W_ISSUE;
                end
            end
            S_F_ISSUE: begin
                addr_d  = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(fcnt_q);
                en_d    = 1'b1;
                state_d = S_F_CAPT;
            end
            S_F_CAPT: begin
                row_d    = data_in;
                ridx_d   = fcnt_q;
                rvalid_d = 1'b1;
                en_d     = 1'b0;
                state_d  = S_F_HOLD;
            end
            S_F_HOLD: begin
                if (fm_row_ready) begin
                    rvalid_d = 1'b0;
                    if (fcnt_q == FR_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        fcnt_d  = fcnt_q + IDX_W'(1);
                        state_d = S_F_ISSUE;
                    end
                end
            end
            S_DONE: begin
                en_d = 1'b0;
                // Re-arming needs start low first, so a held start cannot retrigger.
                if (!start) begin
                    done_d   = 1'b0;
                    wvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign read_address  = addr_q;
    assign enable_read   = en_q;
    assign weight_buf    = wbuf_q;
    assign weights_valid = wvalid_q;
    assign fm_row_data   = row_q;
    assign fm_row_idx    = ridx_q;
    assign fm_row_valid  = rvalid_q;
    assign done          = done_q;

endmodule

// File: tb/tb_gcn_mem_fetch.sv
// Scoreboard bench for gcn_mem_fetch: a memory model feeds data_in, expectations are queued
// per pass and separate monitors check reads, weights and accepted feature rows.
module tb_gcn_mem_fetch;

    localparam int WR = 96;
    localparam int WC = 3;
    localparam int FR = 6;
    localparam int WW = 5;
    localparam int AW = 13;
    localparam int FB = 512;

    typedef logic [0:WR-1][WW-1:0]         vec_t;
    typedef logic [0:WC-1][0:WR-1][WW-1:0] wimg_t;
    typedef struct { int idx; vec_t data; } row_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    vec_t          data_in;
    logic [AW-1:0] read_address;
    logic          enable_read;
    wimg_t         weight_buf;
    logic          weights_valid;
    vec_t          fm_row_data;
    logic [2:0]    fm_row_idx;
    logic          fm_row_valid;
    logic          fm_row_ready = 1'b0;
    logic          done;

    gcn_mem_fetch dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .read_address(read_address), .enable_read(enable_read),
        .weight_buf(weight_buf), .weights_valid(weights_valid),
        .fm_row_data(fm_row_data), .fm_row_idx(fm_row_idx),
        .fm_row_valid(fm_row_valid), .fm_row_ready(fm_row_ready), .done(done)
    );

    always #5 clk = ~clk;

    vec_t wmem [WC];
    vec_t fmem [FR];

    // Memory answers combinationally from the address; unmapped addresses read zero.
    always_comb begin
        data_in = '0;
        if (int'(read_address) < WC)
            data_in = wmem[int'(read_address)];
        else if (int'(read_address) >= FB && int'(read_address) < FB + FR)
            data_in = fmem[int'(read_address) - FB];
    end

    int    n_tests = 0;
    int    n_fail  = 0;
    int    exp_addr[$];
    row_t  exp_rows[$];
    wimg_t exp_w[$];
    int    rmode = 0;
    int    stall = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill_mem(input bit pattern);
        for (int c = 0; c < WC; c++)
            for (int k = 0; k < WR; k++)
                wmem[c][k] = pattern ? WW'((c * 7 + k) % 32) : WW'($urandom);
        for (int r = 0; r < FR; r++)
            for (int k = 0; k < WR; k++)
                fmem[r][k] = WW'($urandom);
    endtask

    // Expected behaviour of one pass: every weight address in order, then every feature
    // address; the weight image is the weight memory; rows arrive in index order.
    task automatic prep_pass();
        wimg_t img;
        for (int c = 0; c < WC; c++) begin
            exp_addr.push_back(c);
            img[c] = wmem[c];
        end
        exp_w.push_back(img);
        for (int r = 0; r < FR; r++) begin
            row_t e;
            exp_addr.push_back(FB + r);
            e.idx  = r;
            e.data = fmem[r];
            exp_rows.push_back(e);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, 64'(read_address), 0);
        chk({tag, "_en"}, 64'(enable_read), 0);
        chk({tag, "_wbuf_zero"}, 64'(weight_buf == '0), 1);
        chk({tag, "_wvalid"}, 64'(weights_valid), 0);
        chk({tag, "_row_zero"}, 64'(fm_row_data == '0), 1);
        chk({tag, "_idx"}, 64'(fm_row_idx), 0);
        chk({tag, "_rvalid"}, 64'(fm_row_valid), 0);
        chk({tag, "_done"}, 64'(done), 0);
    endtask

    task automatic run_pass(input int mode, input bit chk_lat);
        int cyc;
        bit got;
        prep_pass();
        rmode = mode;
        stall = 0;
        start = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
        end
        chk("done_seen", 64'(got), 1);
        if (chk_lat) chk("done_latency", 64'(cyc - 1), 24);
        repeat (3) begin
            @(posedge clk); #1;
            chk("done_hold", 64'(done), 1);
            chk("no_read_in_done", 64'(enable_read), 0);
            chk("wvalid_in_done", 64'(weights_valid), 1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_clear", 64'(done), 0);
        chk("wvalid_clear", 64'(weights_valid), 0);
        chk("addr_q_drained", 64'(exp_addr.size()), 0);
        chk("rows_drained", 64'(exp_rows.size()), 0);
        chk("weights_drained", 64'(exp_w.size()), 0);
    endtask

    // Ready driver: tied high, random, a 5-cycle stall on row 2, or stalled forever on row 3.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: fm_row_ready = 1'b1;
            1: fm_row_ready = 1'($urandom_range(0, 1));
            2: begin
                if (fm_row_valid && fm_row_idx == 3'd2 && stall < 5) begin
                    fm_row_ready = 1'b0;
                    stall++;
                end else fm_row_ready = 1'b1;
            end
            default: fm_row_ready = !(fm_row_valid && fm_row_idx == 3'd3);
        endcase
    end

    // Monitors sample on the falling edge, mid-way between the edges the DUT acts on.
    bit   wv_seen = 1'b0;
    bit   prev_valid = 1'b0;
    bit   prev_acc = 1'b0;
    vec_t prev_data;
    int   prev_idx = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (enable_read) begin
                if (exp_addr.size() == 0) chk("unexpected_read", 64'(read_address), 64'hFFFF);
                else chk("read_addr", 64'(read_address), 64'(exp_addr.pop_front()));
            end
            if (weights_valid && !wv_seen) begin
                wv_seen = 1'b1;
                if (exp_w.size() == 0) chk("unexpected_wvalid", 1, 0);
                else begin
                    wimg_t e;
                    int bad_c, bad_k;
                    e = exp_w.pop_front();
                    bad_c = -1;
                    bad_k = -1;
                    for (int c = 0; c < WC; c++)
                        for (int k = 0; k < WR; k++)
                            if (bad_c < 0 && weight_buf[c][k] !== e[c][k]) begin
                                bad_c = c;
                                bad_k = k;
                            end
                    n_tests++;
                    if (bad_c >= 0) begin
                        n_fail++;
                        $display("FAIL weight_buf[%0d][%0d]: got %0d expected %0d",
                                 bad_c, bad_k, weight_buf[bad_c][bad_k], e[bad_c][bad_k]);
                    end
                end
            end
            if (!weights_valid) wv_seen = 1'b0;
            if (fm_row_valid) begin
                chk("no_read_while_valid", 64'(enable_read), 0);
                if (prev_valid && !prev_acc) begin
                    chk("hold_idx", 64'(fm_row_idx), 64'(prev_idx));
                    chk("hold_data", 64'(fm_row_data == prev_data), 1);
                end
            end
            if (fm_row_valid && fm_row_ready) begin
                if (exp_rows.size() == 0) chk("unexpected_row", 64'(fm_row_idx), 64'hFFFF);
                else begin
                    row_t e;
                    e = exp_rows.pop_front();
                    chk("row_idx", 64'(fm_row_idx), 64'(e.idx));
                    n_tests++;
                    if (fm_row_data !== e.data) begin
                        n_fail++;
                        $display("FAIL row_data idx %0d: got %h expected %h", e.idx, fm_row_data, e.data);
                    end
                end
            end
            prev_valid = fm_row_valid;
            prev_acc   = fm_row_valid && fm_row_ready;
            prev_data  = fm_row_data;
            prev_idx   = int'(fm_row_idx);
        end else begin
            prev_valid = 1'b0;
            wv_seen    = 1'b0;
        end
    end

    initial begin
        int cyc;
        fill_mem(1'b1);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check_zero("idle");

        // Defined weight pattern, ready tied high, then an identical second pass.
        run_pass(0, 1'b1);
        run_pass(0, 1'b1);

        // Five-cycle stall on row 2.
        fill_mem(1'b0);
        run_pass(2, 1'b0);

        // Random ready, including pulses while no row is valid.
        for (int i = 0; i < 3; i++) begin
            fill_mem(1'b0);
            run_pass(1, 1'b0);
        end

        // Asynchronous reset while row 3 is being held.
        fill_mem(1'b0);
        prep_pass();
        rmode = 3;
        start = 1'b1;
        cyc = 0;
        while (!(fm_row_valid && fm_row_idx == 3'd3) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reached_row3_hold", 64'(fm_row_valid && fm_row_idx == 3'd3), 1);
        @(posedge clk); #2;
        reset = 1'b1;
        start = 1'b0;
        #1 check_zero("async_reset");
        exp_addr.delete();
        exp_rows.delete();
        exp_w.delete();
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        run_pass(0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
